// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode constants: bus widths, opcode field layout, HALT and NOP encodings,
// and the fetch FSM state type.
package instruction_fetch_pkg;

    localparam int unsigned IF_ADDR_WIDTH   = 8;
    localparam int unsigned IF_INST_WIDTH   = 32;
    localparam int unsigned OPCODE_WIDTH    = 6;
    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 6'h3F;
    localparam logic [IF_INST_WIDTH-1:0] NOP_INST   = 32'h0000_0000;
    localparam logic [IF_ADDR_WIDTH-1:0] RESET_PC   = 8'h00;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: holds on stall, loads a bubble on redirect/halt,
// otherwise captures the fetched word with its address.
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int unsigned INST_WIDTH = IF_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold_i,
    input  logic                  bubble_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o
);

    logic [INST_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  valid_q;

    // Pipeline register: reset > hold > bubble > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            inst_q  <= inst_q;
            pc_q    <= pc_q;
            valid_q <= valid_q;
        end else if (bubble_i) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, redirect/halt FSM and the IF/ID register feeding decode.
// The instruction memory reads combinationally at pc.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int unsigned INST_WIDTH = IF_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [INST_WIDTH-1:0] if_id_instruction,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic                  if_id_valid,
    output logic                  halted
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ifid_hold_s;
    logic                  ifid_bubble_s;
    logic                  is_halt_s;

    assign is_halt_s = (instruction[INST_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

    // Next-PC / next-state selection: flush > stall > halted > jump > halt-detect > sequential.
    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        ifid_hold_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        if (flush) begin
            pc_d          = branch_target;
            state_d       = ST_RUN;
            ifid_bubble_s = 1'b1;
        end else if (stall) begin
            ifid_hold_s   = 1'b1;
        end else if (state_q == ST_HALTED) begin
            // Parked: the HALT word already went to decode, so only bubbles follow.
            ifid_bubble_s = 1'b1;
        end else if (jump) begin
            pc_d          = jump_target;
            ifid_bubble_s = 1'b1;
        end else if (is_halt_s) begin
            state_d       = ST_HALTED;
        end else begin
            pc_d          = pc_q + ADDR_WIDTH'(1);
        end
    end

    // PC register and fetch FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (ifid_hold_s),
        .bubble_i (ifid_bubble_s),
        .inst_i   (instruction),
        .pc_i     (pc_q),
        .inst_o   (if_id_instruction),
        .pc_o     (if_id_pc),
        .valid_o  (if_id_valid)
    );

    assign pc     = pc_q;
    assign halted = (state_q == ST_HALTED);

endmodule
